psi_input_loader: RTL and testbench
===================================

// Module: psi_input_loader
// PURPOSE
//  Write side of the psi core's p_input bus. Collects each party's sorted set, one W-bit element per
//  accepted beat, into a K*N-element buffer and presents it as the flat bus the psi core consumes.
//  Checks per-party strict ascending order. Asserts p_valid when the whole bus is loaded.
// PARAMETERS
//  W  16  bit width of each set element
//  K  16  elements per party (even)
//  N  4   number of parties (power of 2, >=2)
// PORTS
//  clk        in   1        clock, rising edge
//  rst_n      in   1        asynchronous active-low reset
//  start      in   1        one-cycle pulse: clear buffer and begin a new load
//  in_valid   in   1        in_data holds an element
//  in_ready   out  1        loader accepts an element this cycle
//  in_data    in   W        element, unsigned
//  p_input    out  W*K*N    flat buffer to psi core; element j of party i at [(i*K+j)*W +: W]
//  p_valid    out  1        buffer complete and stable
//  order_err  out  1        sticky: some party sent a non-ascending element
//  err_party  out  log2(N)  party index of the first order violation
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE; p_input=0; p_valid=0; in_ready=0; order_err=0;
//    err_party=0; party counter pi=0; element counter ej=0.
//  - FSM IDLE -> LOAD on start. LOAD -> DONE on acceptance of last element. DONE -> LOAD on start.
//  - Entering LOAD (cycle after start): p_input cleared to 0; pi=ej=0; order_err=err_party=0;
//    p_valid=0. in_ready=1 throughout LOAD (registered, first high the cycle after start).
//  - Accept = in_valid & in_ready. On accept: write in_data to slot (pi*K+ej); increment ej;
//    at ej=K-1 wrap ej to 0 and increment pi. Order is party-major: all K of party 0, then party 1, ...
//  - Last element (pi=N-1, ej=K-1) accepted: next cycle state=DONE, in_ready=0, p_valid=1.
//    p_input is held unchanged in DONE. Latency: last accept to p_valid=1 is 1 cycle.
//  - in_valid while in_ready=0 (IDLE/DONE): ignored, nothing written.
//  - start during LOAD: abort. Same clear as entering LOAD; partial data is discarded.
//  - start in the same cycle as an accept: start wins and the element is dropped.
//  - Order rule (ej>=1): in_data must be strictly > the previous element of the same party.
//    Equal or smaller is a violation. ej=0 has no predecessor and is never checked.
//    The previous element is held in a W-bit register, not read back from the buffer.
//  - On the first violation: order_err=1 and err_party=pi, both visible the next cycle.
//    Later violations do not change err_party. Loading continues normally and p_valid still asserts.
//  - The wide bus is not registered twice. p_input is driven directly from the buffer flops.
// CONFIGURATION
//  - PSI_LOADER_ORDER_CHECK_EN defined: order check, order_err and err_party as above.
//  - Not defined: previous-element register and comparator removed.
//    order_err and err_party are tied to 0. All other behaviour is identical.
// TESTING
//  - Reset mid-LOAD after 5 accepts -> all outputs 0 immediately; in_ready=0 until the next start.
//  - K=16,N=4, start, then 64 beats with party i element j = i*100+j, in_valid held 1:
//    in_ready high 64 cycles; p_valid=1 exactly 1 cycle after beat 64;
//    slot 17 (party 1, j=1) = 101; order_err=0.
//  - Same stream with in_valid toggling 1/0 every cycle -> identical p_input;
//    p_valid 1 cycle after the 64th accept.
//  - Party 2 element 5 = party 2 element 4 (duplicate), and party 3 element 3 < element 2:
//    order_err=1, err_party=2 (first violation kept), p_valid=1 after 64 beats.
//  - start after 30 accepts, then 64 fresh beats -> p_input holds only new data;
//    no residue from the first 30 beats.
//  - In DONE, drive in_valid=1 with data 16'hFFFF for 10 cycles -> p_input unchanged;
//    in_ready=0; p_valid stays 1.

Source files
------------

// File: rtl/psi_input_loader.sv
// Loader for the psi core's p_input bus: collects N parties x K sorted elements into a flat buffer.
// Optional per-party strict-ascending order check enabled by defining PSI_LOADER_ORDER_CHECK_EN.
module psi_input_loader #(
    parameter int W = 16,
    parameter int K = 16,
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         in_data,
    output logic [W*K*N-1:0]     p_input,
    output logic                 p_valid,
    output logic                 order_err,
    output logic [$clog2(N)-1:0] err_party
);
    localparam int PW = $clog2(N);
    localparam int EW = $clog2(K);
    localparam int NK = N * K;
    localparam int SW = $clog2(NK);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t              state;
    logic [PW-1:0]       pi;
    logic [EW-1:0]       ej;
    logic                accept;
    logic                last_elem;
    logic [SW-1:0]       slot;
    logic [NK-1:0][W-1:0] buf_q;

    assign accept    = in_valid & in_ready;
    assign last_elem = (pi == PW'(N - 1)) && (ej == EW'(K - 1));
    assign slot      = SW'(pi) * SW'(K) + SW'(ej);
    assign p_input   = buf_q;

    // start has priority over everything, so an element accepted in a start cycle is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            p_valid  <= 1'b0;
            pi       <= '0;
            ej       <= '0;
        end else if (start) begin
            state    <= LOAD;
            in_ready <= 1'b1;
            p_valid  <= 1'b0;
            pi       <= '0;
            ej       <= '0;
        end else if (state == LOAD && accept) begin
            if (last_elem) begin
                state    <= DONE;
                in_ready <= 1'b0;
                p_valid  <= 1'b1;
                pi       <= '0;
                ej       <= '0;
            end else if (ej == EW'(K - 1)) begin
                ej <= '0;
                pi <= pi + 1'b1;
            end else begin
                ej <= ej + 1'b1;
            end
        end
    end

    // one storage slot per element; the bus is taken straight from these flops
    for (genvar s = 0; s < NK; s++) begin : g_slot
        psi_loader_slot #(.W(W)) u_slot (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (start),
            .we    (accept && (slot == SW'(s))),
            .d     (in_data),
            .q     (buf_q[s])
        );
    end

`ifdef PSI_LOADER_ORDER_CHECK_EN
    logic [W-1:0] prev_q;

    // only the first violation is latched; err_party then stays frozen until the next start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q    <= '0;
            order_err <= 1'b0;
            err_party <= '0;
        end else if (start) begin
            order_err <= 1'b0;
            err_party <= '0;
        end else if (accept) begin
            prev_q <= in_data;
            if ((ej != '0) && (in_data <= prev_q) && !order_err) begin
                order_err <= 1'b1;
                err_party <= pi;
            end
        end
    end
`else
    assign order_err = 1'b0;
    assign err_party = '0;
`endif

endmodule

// Single element register of the loader buffer: synchronous clear beats write.
module psi_loader_slot #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         we,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   q <= '0;
        else if (clr) q <= '0;
        else if (we)  q <= d;
    end
endmodule

// File: tb/tb_psi_input_loader.sv
// Bench for psi_input_loader: randomized sorted sets checked against a set-level reference model.
// Order-check expectations follow PSI_LOADER_ORDER_CHECK_EN.
module tb_psi_input_loader;
    localparam int W  = 16;
    localparam int K  = 16;
    localparam int N  = 4;
    localparam int NK = N * K;
    localparam int PW = $clog2(N);

    logic              clk = 1'b0;
    logic              rst_n, start, in_valid, in_ready;
    logic [W-1:0]      in_data;
    logic [W*NK-1:0]   p_input;
    logic              p_valid, order_err;
    logic [PW-1:0]     err_party;

    int vectors = 0;
    int miscompares = 0;
    logic [W-1:0] stim [NK];

    always #5 clk = ~clk;

    psi_input_loader #(.W(W), .K(K), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .p_input   (p_input),
        .p_valid   (p_valid),
        .order_err (order_err),
        .err_party (err_party)
    );

    // Reference: party i element j lives at element position i*K+j of the flat bus
    function automatic logic [W*NK-1:0] exp_bus();
        logic [W*NK-1:0] b = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < K; j++)
                b[(i*K+j)*W +: W] = stim[i*K+j];
        return b;
    endfunction

    function automatic int first_diff(input logic [W*NK-1:0] a, input logic [W*NK-1:0] b);
        for (int s = 0; s < NK; s++)
            if (a[s*W +: W] !== b[s*W +: W]) return s;
        return -1;
    endfunction

    // Reference: scan each party's set for the first non-increasing element
    function automatic void ref_order(output bit e, output int p);
        e = 1'b0; p = 0;
`ifdef PSI_LOADER_ORDER_CHECK_EN
        for (int i = 0; i < N; i++)
            for (int j = 1; j < K; j++)
                if (!e && stim[i*K+j] <= stim[i*K+j-1]) begin e = 1'b1; p = i; end
`endif
    endfunction

    task automatic fill_pattern();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < K; j++)
                stim[i*K+j] = W'(i*100 + j);
    endtask

    task automatic fill_random();
        int v;
        for (int i = 0; i < N; i++) begin
            v = $urandom_range(0, 200);
            for (int j = 0; j < K; j++) begin
                stim[i*K+j] = W'(v);
                v += $urandom_range(1, 60);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Feeds stim[0..NK-1]; reports ready cycles, p_valid before/after the last accept, timeout
    task automatic drive_stream(input bit toggle, output int rdy_cyc, output bit pv_pre,
                                output bit pv_post, output bit tout);
        int idx, cyc;
        bit acc;
        idx = 0; cyc = 0; rdy_cyc = 0; pv_pre = 1'b0; pv_post = 1'b0;
        while (idx < NK && cyc < 2000) begin
            in_valid = toggle ? (cyc % 2 == 0) : 1'b1;
            in_data  = stim[idx];
            acc = in_valid && in_ready;
            if (in_ready) rdy_cyc++;
            if (acc && idx == NK-1) pv_pre = p_valid;
            tick();
            if (acc) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        tout = (idx < NK);
        pv_post = p_valid;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
        #12;
        vectors++;
        if ({p_valid, in_ready, order_err} !== 3'b000 || err_party !== '0 || p_input !== '0) begin
            miscompares++;
            $display("FAIL reset_state: p_valid=%b in_ready=%b order_err=%b err_party=%0d bus_zero=%b, want all 0",
                     p_valid, in_ready, order_err, err_party, p_input == '0);
        end
        rst_n = 1'b1;
        in_valid = 1'b1; in_data = 16'h1234;
        for (int c = 0; c < 3; c++) begin
            tick();
            vectors++;
            if (in_ready !== 1'b0 || p_input !== '0) begin
                miscompares++;
                $display("FAIL idle_ignore: in_ready=%b bus_zero=%b, want 0/1", in_ready, p_input == '0);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_stream();
        int rdy; bit pre, post, to, ee; int ep, d;
        fill_pattern();
        do_start();
        vectors++;
        if (in_ready !== 1'b1 || p_valid !== 1'b0 || p_input !== '0) begin
            miscompares++;
            $display("FAIL stream_enter: in_ready=%b p_valid=%b bus_zero=%b, want 1/0/1", in_ready, p_valid, p_input == '0);
        end
        drive_stream(1'b0, rdy, pre, post, to);
        vectors++;
        if (to) begin miscompares++; $display("FAIL stream_timeout: stream did not complete"); end
        vectors++;
        if (rdy !== NK) begin miscompares++; $display("FAIL stream_ready_cycles: got %0d want %0d", rdy, NK); end
        vectors++;
        if (pre !== 1'b0 || post !== 1'b1 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL stream_latency: p_valid pre=%b post=%b in_ready=%b, want 0/1/0", pre, post, in_ready);
        end
        vectors++;
        if (p_input[17*W +: W] !== 16'd101) begin
            miscompares++; $display("FAIL stream_slot17: got %0d want 101", p_input[17*W +: W]);
        end
        vectors++;
        if (p_input !== exp_bus()) begin
            d = first_diff(p_input, exp_bus()); miscompares++;
            $display("FAIL stream_bus: slot %0d got %h want %h", d, p_input[d*W +: W], stim[d]);
        end
        ref_order(ee, ep);
        vectors++;
        if (order_err !== ee) begin miscompares++; $display("FAIL stream_order_err: got %b want %b", order_err, ee); end
    endtask

    task automatic test_done_hold();
        logic [W*NK-1:0] held;
        held = exp_bus();
        in_valid = 1'b1; in_data = 16'hFFFF;
        for (int c = 0; c < 10; c++) begin
            tick();
            vectors++;
            if (in_ready !== 1'b0 || p_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL done_hold_flags: cycle %0d in_ready=%b p_valid=%b, want 0/1", c, in_ready, p_valid);
            end
        end
        in_valid = 1'b0;
        vectors++;
        if (p_input !== held) begin
            miscompares++; $display("FAIL done_hold_bus: slot %0d changed", first_diff(p_input, held));
        end
    endtask

    task automatic test_toggle();
        int rdy, d; bit pre, post, to;
        fill_pattern();
        do_start();
        drive_stream(1'b1, rdy, pre, post, to);
        vectors++;
        if (to || pre !== 1'b0 || post !== 1'b1) begin
            miscompares++; $display("FAIL toggle_latency: timeout=%b p_valid pre=%b post=%b, want 0/0/1", to, pre, post);
        end
        vectors++;
        if (p_input !== exp_bus()) begin
            d = first_diff(p_input, exp_bus()); miscompares++;
            $display("FAIL toggle_bus: slot %0d got %h want %h", d, p_input[d*W +: W], stim[d]);
        end
    endtask

    task automatic test_order();
        int rdy, ep; bit pre, post, to, ee;
        fill_pattern();
        stim[2*K+5] = stim[2*K+4];
        stim[3*K+3] = W'(300);
        ref_order(ee, ep);
        do_start();
        drive_stream(1'b0, rdy, pre, post, to);
        vectors++;
        if (to || post !== 1'b1) begin miscompares++; $display("FAIL order_pvalid: timeout=%b p_valid=%b", to, post); end
        vectors++;
        if (order_err !== ee || err_party !== PW'(ep)) begin
            miscompares++;
            $display("FAIL order_dup_desc: order_err=%b err_party=%0d, want %b/%0d", order_err, err_party, ee, ep);
        end
    endtask

    task automatic test_abort();
        int rdy, d; bit pre, post, to;
        fill_random();
        do_start();
        in_valid = 1'b1;
        for (int c = 0; c < 30; c++) begin in_data = stim[c]; tick(); end
        start = 1'b1; in_data = stim[30];
        tick();
        start = 1'b0; in_valid = 1'b0;
        vectors++;
        if (p_input !== '0 || in_ready !== 1'b1 || p_valid !== 1'b0 || order_err !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_clear: bus_zero=%b in_ready=%b p_valid=%b order_err=%b", p_input == '0, in_ready, p_valid, order_err);
        end
        fill_random();
        drive_stream(1'b0, rdy, pre, post, to);
        vectors++;
        if (to || post !== 1'b1 || p_input !== exp_bus()) begin
            d = first_diff(p_input, exp_bus()); miscompares++;
            $display("FAIL abort_reload: timeout=%b p_valid=%b first bad slot %0d", to, post, d);
        end
    endtask

    task automatic test_random();
        int rdy, ep, p, j, d; bit pre, post, to, ee;
        for (int it = 0; it < 4; it++) begin
            fill_random();
            for (int k = 0; k < it; k++) begin
                p = $urandom_range(0, N-1);
                j = $urandom_range(1, K-1);
                stim[p*K+j] = stim[p*K+j-1] - W'($urandom_range(0, int'(stim[p*K+j-1])));
            end
            ref_order(ee, ep);
            do_start();
            drive_stream(it[0], rdy, pre, post, to);
            vectors++;
            if (to || post !== 1'b1 || p_input !== exp_bus()) begin
                d = first_diff(p_input, exp_bus()); miscompares++;
                $display("FAIL random_bus it%0d: timeout=%b p_valid=%b first bad slot %0d", it, to, post, d);
            end
            vectors++;
            if (order_err !== ee || (ee && err_party !== PW'(ep))) begin
                miscompares++;
                $display("FAIL random_order it%0d: order_err=%b err_party=%0d, want %b/%0d", it, order_err, err_party, ee, ep);
            end
        end
    endtask

    task automatic test_reset_mid();
        fill_random();
        do_start();
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin in_data = stim[c]; tick(); end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({p_valid, in_ready, order_err} !== 3'b000 || err_party !== '0 || p_input !== '0) begin
            miscompares++;
            $display("FAIL reset_mid: p_valid=%b in_ready=%b order_err=%b bus_zero=%b, want all 0",
                     p_valid, in_ready, order_err, p_input == '0);
        end
        @(negedge clk) rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            vectors++;
            if (in_ready !== 1'b0 || p_input !== '0) begin
                miscompares++; $display("FAIL reset_mid_idle: in_ready=%b bus_zero=%b", in_ready, p_input == '0);
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_done_hold();
        test_toggle();
        test_order();
        test_abort();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
